// File: rtl/tri_fetch_sequencer.sv
// rtl/tri_fetch_sequencer.sv - fetches nine-word triangles from the model ROM and presents them
// one at a time over a valid/ready handshake.
module tri_fetch_sequencer #(
  parameter int addr_width = 8,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [addr_width-1:0]   base_addr,
  input  logic [7:0]              tri_count,
  output logic [addr_width-1:0]   rom_addr,
  input  logic [data_width-1:0]   rom_data,
  output logic                    tri_valid,
  input  logic                    tri_ready,
  output logic [9*data_width-1:0] tri_data,
  output logic [7:0]              tri_index,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [7:0]              count_q, count_d;
  logic [3:0]              k_q, k_d;
  logic [7:0]              idx_q, idx_d;
  logic [9*data_width-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    k_d     = k_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          count_d = tri_count;
          k_d     = '0;
          idx_d   = '0;
          state_d = (tri_count == 8'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        for (int w = 0; w < 9; w++) begin
          if (k_q == 4'(w)) data_d[w*data_width +: data_width] = rom_data;
        end
        // Address wraps naturally; after the ninth word it already points at the next triangle.
        addr_d = addr_q + 1'b1;
        if (k_q == 4'd8) begin
          k_d     = '0;
          state_d = S_PRESENT;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_PRESENT: begin
        if (tri_ready) begin
          if ({1'b0, idx_q} + 9'd1 < {1'b0, count_q}) begin
            idx_d   = idx_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_addr  = addr_q;
  assign tri_data  = data_q;
  assign tri_index = idx_q;
  assign tri_valid = (state_q == S_PRESENT);
  assign busy      = (state_q == S_FETCH) || (state_q == S_PRESENT);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_tri_fetch_sequencer.sv
// tb/tb_tri_fetch_sequencer.sv - randomized and directed checks of tri_fetch_sequencer against a
// schedule-based reference model.
module tb_tri_fetch_sequencer;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [7:0]    tri_count;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          tri_valid;
  logic          tri_ready;
  logic [9*DW-1:0] tri_data;
  logic [7:0]    tri_index;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom_mem [256];

  always #5 clk = ~clk;
  assign rom_data = rom_mem[rom_addr];

  tri_fetch_sequencer #(.addr_width(AW), .data_width(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .tri_count (tri_count),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tri_valid (tri_valid),
    .tri_ready (tri_ready),
    .tri_data  (tri_data),
    .tri_index (tri_index),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_mis = 0;

  bit          rdy     [MAXC];
  bit          e_valid [MAXC];
  bit          e_busy  [MAXC];
  logic [7:0]  e_addr  [MAXC];
  logic [7:0]  e_idx   [MAXC];
  int          e_done;
  logic [9*DW-1:0] first_tri;
  logic [9*DW-1:0] last_tri;

  logic [DW-1:0] exp_t0   [9] = '{10, 20, 800, 35, 40, 660, 30, 60, 700};
  logic [DW-1:0] exp_t1   [9] = '{36, 41, 660, 31, 61, 700, 45, 50, 750};
  logic [DW-1:0] exp_wrap [9] = '{0, 0, 0, 0, 10, 20, 800, 35, 40};

  task automatic check_val(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_words(input string tag, input logic [9*DW-1:0] v, input logic [DW-1:0] w [9]);
    for (int k = 0; k < 9; k++) check_val($sformatf("%s_w%0d", tag, k), v[k*DW +: DW], w[k]);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle behaviour derived from the triangle schedule: each triangle
  // fetches for nine cycles, then waits for the first ready cycle to hand over.
  task automatic build_model(input logic [7:0] base, input logic [7:0] cnt);
    int f;
    int t;
    for (int c = 0; c < MAXC; c++) begin
      e_valid[c] = 0;
      e_busy[c]  = 0;
      e_addr[c]  = '0;
      e_idx[c]   = '0;
    end
    f = 1;
    for (int i = 0; i < int'(cnt); i++) begin
      for (int j = 0; j < 9; j++) begin
        e_busy[f+j] = 1;
        e_addr[f+j] = base + 8'(9*i + j);
        e_idx[f+j]  = 8'(i);
      end
      t = f + 9;
      while (!rdy[t]) t++;
      for (int c = f + 9; c <= t; c++) begin
        e_valid[c] = 1;
        e_busy[c]  = 1;
        e_addr[c]  = base + 8'(9*(i+1));
        e_idx[c]   = 8'(i);
      end
      f = t + 1;
    end
    e_done = f;
  endtask

  task automatic run(input logic [7:0] base, input logic [7:0] cnt, input bit rand_ready, input int hold_low);
    logic [7:0]      a;
    logic [9*DW-1:0] expd;
    for (int c = 0; c < MAXC; c++)
      rdy[c] = rand_ready ? (($urandom_range(0, 1) == 1) || (c % 6 == 5)) : (c >= hold_low);
    build_model(base, cnt);
    start     = 1'b1;
    base_addr = base;
    tri_count = cnt;
    tri_ready = rdy[0];
    for (int c = 1; c <= e_done + 1; c++) begin
      step;
      check_val($sformatf("valid_c%0d", c), tri_valid, e_valid[c]);
      check_val($sformatf("busy_c%0d", c), busy, e_busy[c]);
      check_val($sformatf("done_c%0d", c), done, (c == e_done));
      if (e_busy[c]) begin
        check_val($sformatf("addr_c%0d", c), rom_addr, e_addr[c]);
        check_val($sformatf("index_c%0d", c), tri_index, e_idx[c]);
      end
      if (e_valid[c]) begin
        for (int k = 0; k < 9; k++) begin
          a = base + e_idx[c] * 8'd9 + 8'(k);
          expd[k*DW +: DW] = rom_mem[a];
        end
        check_val($sformatf("data_c%0d", c), tri_data, expd);
        last_tri = tri_data;
        if (c == 10) first_tri = tri_data;
      end
      start     = e_busy[c] ? 1'($urandom_range(0, 1)) : 1'b0;
      base_addr = 8'($urandom);
      tri_count = 8'($urandom);
      tri_ready = rdy[c];
    end
    start     = 1'b0;
    tri_ready = 1'b0;
  endtask

  task automatic reset_mid;
    start     = 1'b1;
    base_addr = 8'd0;
    tri_count = 8'd2;
    tri_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step;
      start = 1'b0;
    end
    rst_n = 1'b0;
    step;
    check_val("rst_mid_addr", rom_addr, 0);
    check_val("rst_mid_data", tri_data, 0);
    check_val("rst_mid_index", tri_index, 0);
    check_val("rst_mid_valid", tri_valid, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_done", done, 0);
    rst_n = 1'b1;
    tri_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      check_val($sformatf("rst_idle_done%0d", c), done, 0);
      check_val($sformatf("rst_idle_busy%0d", c), busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = (i >= 18 && i < 252) ? $urandom : '0;
    for (int i = 0; i < 9; i++) begin
      rom_mem[i]   = exp_t0[i];
      rom_mem[9+i] = exp_t1[i];
    end
    rst_n     = 1'b0;
    start     = 1'b0;
    tri_ready = 1'b0;
    base_addr = '0;
    tri_count = '0;
    step;
    step;
    rst_n = 1'b1;
    check_val("reset_addr", rom_addr, 0);
    check_val("reset_data", tri_data, 0);
    check_val("reset_index", tri_index, 0);
    check_val("reset_valid", tri_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    step;

    run(8'd0, 8'd1, 1'b0, 0);
    check_words("one_tri", first_tri, exp_t0);
    run(8'd0, 8'd2, 1'b0, 0);
    check_words("two_tri_a", first_tri, exp_t0);
    check_words("two_tri_b", last_tri, exp_t1);
    run(8'd0, 8'd2, 1'b0, 15);
    check_words("bp_tri_b", last_tri, exp_t1);
    run(8'hFC, 8'd1, 1'b0, 0);
    check_words("wrap", first_tri, exp_wrap);
    run(8'h33, 8'd0, 1'b0, 0);
    reset_mid;
    run(8'd0, 8'd1, 1'b0, 0);
    check_words("after_rst", first_tri, exp_t0);

    repeat (12) run(8'($urandom), 8'($urandom_range(0, 5)), 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
